// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into instruction bits [31:7] for the
// selected RISC-V format, flags out-of-range values, and buffers results in a 2-entry FIFO.
module imm_encoder (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] imm_i,
   input  logic [2:0]  imm_src_i,
   input  logic        signed_i,
   input  logic [24:0] fields_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [24:0] instr_31_7_o,
   output logic        range_err_o,
   output logic [7:0]  err_cnt_o
);

   localparam int unsigned IMM_W   = 32;
   localparam int unsigned INSTR_W = 25;
   localparam int unsigned OCC_W   = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DEPTH   = 2;

   typedef enum logic [2:0] {
      SRC_I     = 3'b000,
      SRC_S     = 3'b001,
      SRC_B     = 3'b010,
      SRC_U     = 3'b011,
      SRC_J     = 3'b100,
      SRC_SHAMT = 3'b101,
      SRC_ILL   = 3'b110,
      SRC_UB    = 3'b111
   } imm_src_e;

   typedef struct packed {
      logic               err;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [IMM_W-1:0] imm;
   entry_t           enc;
   entry_t           mem [DEPTH];
   entry_t           head;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_next;
   logic             ready_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic             push;
   logic             pop;

   // Sign-extension range checks: the dropped high bits must all match the kept sign bit.
   logic sext_11;
   logic sext_12;
   logic sext_20;

   assign imm     = imm_i;
   assign sext_11 = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign sext_12 = (imm[31:12] == '0) || (imm[31:12] == '1);
   assign sext_20 = (imm[31:20] == '0) || (imm[31:20] == '1);

   // Format-specific bit placement and range check; untouched bits come from fields_i.
   always_comb begin
      enc.instr = fields_i;
      enc.err   = 1'b0;
      case (imm_src_e'(imm_src_i))
         SRC_I: begin
            enc.instr[24:13] = imm[11:0];
            enc.err          = signed_i ? !sext_11 : (imm[31:12] != '0);
         end
         SRC_S: begin
            enc.instr[24:18] = imm[11:5];
            enc.instr[4:0]   = imm[4:0];
            enc.err          = !sext_11;
         end
         SRC_B: begin
            enc.instr[24]    = imm[12];
            enc.instr[0]     = imm[11];
            enc.instr[23:18] = imm[10:5];
            enc.instr[4:1]   = imm[4:1];
            enc.err          = imm[0] || !sext_12;
         end
         SRC_UB: begin
            enc.instr[24]    = imm[12];
            enc.instr[0]     = imm[11];
            enc.instr[23:18] = imm[10:5];
            enc.instr[4:1]   = imm[4:1];
            enc.err          = imm[0] || (imm[31:13] != '0);
         end
         SRC_U: begin
            enc.instr[24:5] = imm[31:12];
            enc.err         = (imm[11:0] != '0);
         end
         SRC_J: begin
            enc.instr[24]    = imm[20];
            enc.instr[23:14] = imm[10:1];
            enc.instr[13]    = imm[11];
            enc.instr[12:5]  = imm[19:12];
            enc.err          = imm[0] || !sext_20;
         end
         SRC_SHAMT: begin
            enc.instr[17:13] = imm[4:0];
            enc.err          = (imm[31:5] != '0);
         end
         SRC_ILL: begin
            enc.instr = '0;
            enc.err   = 1'b1;
         end
         default: begin
            enc.instr = '0;
            enc.err   = 1'b1;
         end
      endcase
   end

   assign head = mem[rd_ptr];
   assign push = in_valid_i && ready_q;
   assign pop  = (occ != '0) && out_ready_i;

   always_comb begin
      occ_next = occ;
      case ({push, pop})
         2'b10:   occ_next = OCC_W'(occ + 1'b1);
         2'b01:   occ_next = OCC_W'(occ - 1'b1);
         default: occ_next = occ;
      endcase
   end

   // FIFO storage, pointers and the registered ready flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         occ     <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= enc;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ     <= occ_next;
         ready_q <= (occ_next < OCC_W'(DEPTH));
      end
   end

   // Saturating count of delivered erroneous results.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_q <= '0;
      end else if (pop && head.err && (err_cnt_q != '1)) begin
         err_cnt_q <= CNT_W'(err_cnt_q + 1'b1);
      end
   end

   assign in_ready_o   = ready_q;
   assign out_valid_o  = (occ != '0);
   assign instr_31_7_o = head.instr;
   assign range_err_o  = head.err;
   assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, range errors, FIFO backpressure, reset and counter saturation.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] imm;
   logic [2:0]  imm_src;
   logic        sgn;
   logic [24:0] fields;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] instr;
   logic        range_err;
   logic [7:0]  err_cnt;

   int check_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   imm_encoder dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .imm_i        (imm),
      .imm_src_i    (imm_src),
      .signed_i     (sgn),
      .fields_i     (fields),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .instr_31_7_o (instr),
      .range_err_o  (range_err),
      .err_cnt_o    (err_cnt)
   );

   typedef struct {
      logic [2:0]  src;
      logic        sg;
      logic [31:0] im;
      logic [24:0] fl;
      logic [24:0] exp_instr;
      logic        exp_err;
   } vec_t;

   // Presents one request for exactly one cycle; returns at the following negedge.
   task automatic issue(input logic [2:0] s, input logic sg, input logic [31:0] im, input logic [24:0] fl);
      @(negedge clk);
      in_valid = 1'b1;
      imm_src  = s;
      sgn      = sg;
      imm      = im;
      fields   = fl;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Reference decoder (immediate sign-extension as the core's decode stage would do it).
   function automatic logic [31:0] decode(input logic [2:0] s, input logic sg, input logic [24:0] o);
      case (s)
         3'b000:  decode = sg ? {{20{o[24]}}, o[24:13]} : {20'b0, o[24:13]};
         3'b001:  decode = {{20{o[24]}}, o[24:18], o[4:0]};
         3'b010:  decode = {{19{o[24]}}, o[24], o[0], o[23:18], o[4:1], 1'b0};
         3'b111:  decode = {19'b0, o[24], o[0], o[23:18], o[4:1], 1'b0};
         3'b011:  decode = {o[24:5], 12'b0};
         3'b100:  decode = {{11{o[24]}}, o[24], o[12:5], o[13], o[23:14], 1'b0};
         3'b101:  decode = {27'b0, o[17:13]};
         default: decode = 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
      check_cnt++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      check_cnt++; if (instr !== 25'h0) $display("FAIL reset_instr: got %h want 0", instr); else pass_cnt++;
      check_cnt++; if (range_err !== 1'b0) $display("FAIL reset_range_err: got %b want 0", range_err); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_encode();
      vec_t v [16];
      v = '{
         '{3'b000, 1'b1, 32'hFFFFFFFF, 25'h0,       25'h1FFE000, 1'b0},
         '{3'b000, 1'b0, 32'hFFFFFFFF, 25'h0,       25'h1FFE000, 1'b1},
         '{3'b010, 1'b0, 32'hFFFFF000, 25'h0,       25'h1000000, 1'b0},
         '{3'b010, 1'b0, 32'h00000003, 25'h0,       25'h0000002, 1'b1},
         '{3'b011, 1'b0, 32'h12345000, 25'h0,       25'h02468A0, 1'b0},
         '{3'b011, 1'b0, 32'h12345001, 25'h0,       25'h02468A0, 1'b1},
         '{3'b001, 1'b0, 32'h000007FF, 25'h0,       25'h0FC001F, 1'b0},
         '{3'b001, 1'b0, 32'h00000800, 25'h1FFFFFF, 25'h103FFE0, 1'b1},
         '{3'b100, 1'b0, 32'h000FFFFE, 25'h0,       25'h0FFFFE0, 1'b0},
         '{3'b100, 1'b0, 32'h00100000, 25'h0,       25'h1000000, 1'b1},
         '{3'b101, 1'b0, 32'h0000001F, 25'h1FFFFFF, 25'h1FFFFFF, 1'b0},
         '{3'b101, 1'b0, 32'h00000020, 25'h0,       25'h0000000, 1'b1},
         '{3'b111, 1'b0, 32'h00001FFE, 25'h0,       25'h1FC001F, 1'b0},
         '{3'b111, 1'b0, 32'h00002000, 25'h0,       25'h0000000, 1'b1},
         '{3'b110, 1'b0, 32'h00000000, 25'h1FFFFFF, 25'h0000000, 1'b1},
         '{3'b000, 1'b1, 32'h00000800, 25'h0,       25'h1000000, 1'b1}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         issue(v[i].src, v[i].sg, v[i].im, v[i].fl);
         check_cnt++; if (out_valid !== 1'b1) $display("FAIL enc_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
         check_cnt++; if (instr !== v[i].exp_instr) $display("FAIL enc_instr[%0d]: got %h want %h", i, instr, v[i].exp_instr); else pass_cnt++;
         check_cnt++; if (range_err !== v[i].exp_err) $display("FAIL enc_err[%0d]: got %b want %b", i, range_err, v[i].exp_err); else pass_cnt++;
      end
      @(negedge clk);
      check_cnt++; if (err_cnt !== 8'd9) $display("FAIL enc_err_cnt: got %0d want 9", err_cnt); else pass_cnt++;
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL enc_drained: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      imm_src = 3'b000; sgn = 1'b1; fields = 25'h0;
      @(negedge clk); in_valid = 1'b1; imm = 32'd1;
      @(negedge clk); imm = 32'd2;
      check_cnt++; if (instr !== 25'h2000 || out_valid !== 1'b1) $display("FAIL b2b_first: got %b/%h want 1/2000", out_valid, instr); else pass_cnt++;
      @(negedge clk); imm = 32'd3;
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", in_ready); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b want 0", in_ready); else pass_cnt++;
      check_cnt++; if (instr !== 25'h2000) $display("FAIL b2b_stable: got %h want 2000", instr); else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      check_cnt++; if (instr !== 25'h4000) $display("FAIL b2b_second: got %h want 4000", instr); else pass_cnt++;
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_reopen: got %b want 1", in_ready); else pass_cnt++;
      @(negedge clk); in_valid = 1'b0;
      check_cnt++; if (instr !== 25'h6000 || out_valid !== 1'b1) $display("FAIL b2b_third: got %b/%h want 1/6000", out_valid, instr); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      imm_src = 3'b110; sgn = 1'b0; imm = 32'h0; fields = 25'h0;
      @(negedge clk); in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk); in_valid = 1'b0;
      check_cnt++; if (out_valid !== 1'b1 || err_cnt !== 8'd9) $display("FAIL rmid_pre: got %b/%0d want 1/9", out_valid, err_cnt); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else pass_cnt++;
      check_cnt++; if (err_cnt !== 8'd0) $display("FAIL rmid_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", in_ready); else pass_cnt++;
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_stale[%0d]: got %b want 0", i, out_valid); else pass_cnt++;
      end
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_ready_after: got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_saturation();
      int accepted = 0;
      int delivered = 0;
      int cycles = 0;
      int exp_cnt;
      out_ready = 1'b1;
      imm_src = 3'b110; sgn = 1'b0; imm = 32'h0; fields = 25'h1FFFFFF;
      while (delivered < 300 && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (out_valid) begin
            exp_cnt = (delivered > 255) ? 255 : delivered;
            check_cnt++; if (instr !== 25'h0) $display("FAIL sat_instr[%0d]: got %h want 0", delivered, instr); else pass_cnt++;
            check_cnt++; if (range_err !== 1'b1) $display("FAIL sat_err[%0d]: got %b want 1", delivered, range_err); else pass_cnt++;
            check_cnt++; if (err_cnt !== 8'(exp_cnt)) $display("FAIL sat_cnt[%0d]: got %0d want %0d", delivered, err_cnt, exp_cnt); else pass_cnt++;
            delivered++;
         end
         in_valid = (accepted < 300);
         if (in_valid && in_ready) accepted++;
      end
      in_valid = 1'b0;
      check_cnt++; if (delivered != 300) $display("FAIL sat_delivered: got %0d want 300", delivered); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (err_cnt !== 8'd255) $display("FAIL sat_final_cnt: got %0d want 255", err_cnt); else pass_cnt++;
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL sat_drained: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_roundtrip();
      logic [2:0]  srcs [8];
      logic        sgs  [8];
      logic [31:0] r;
      logic [31:0] val;
      logic [31:0] got;
      srcs = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
      sgs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 6; n++) begin
            r = $urandom;
            case (k)
               0, 2:    val = {{20{r[11]}}, r[11:0]};
               1:       val = {20'b0, r[11:0]};
               3:       val = {{19{r[12]}}, r[12:1], 1'b0};
               4:       val = {r[31:12], 12'b0};
               5:       val = {{11{r[20]}}, r[20:1], 1'b0};
               6:       val = {27'b0, r[4:0]};
               default: val = {19'b0, r[12:1], 1'b0};
            endcase
            issue(srcs[k], sgs[k], val, 25'($urandom));
            got = decode(srcs[k], sgs[k], instr);
            check_cnt++; if (got !== val) $display("FAIL rt_value[%0d.%0d]: got %h want %h", k, n, got, val); else pass_cnt++;
            check_cnt++; if (range_err !== 1'b0 || out_valid !== 1'b1) $display("FAIL rt_err[%0d.%0d]: got %b/%b want 0/1", k, n, range_err, out_valid); else pass_cnt++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      imm = 32'h0; imm_src = 3'b000; sgn = 1'b0; fields = 25'h0;
      test_reset();
      test_encode();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      test_roundtrip();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
